// File: rtl/imu_poll_scheduler.sv
// Polls six IMU registers through an SPI command encoder on a fixed cadence.
// Host one-shot requests take priority, and each result is kept in a six-entry bank.
module imu_poll_scheduler #(
    parameter int POLL_DIV = 1000,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        host_req,
    input  logic [2:0]  host_cmd,
    output logic        host_ack,
    input  logic        enc_ready,
    output logic        enc_transmit,
    output logic [2:0]  enc_command,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic [2:0]  rd_sel,
    output logic [15:0] rd_data,
    output logic        upd_valid,
    output logic [2:0]  upd_cmd,
    output logic        busy,
    input  logic        err_clr,
    output logic        timeout_err,
    output logic        overrun_err,
    output logic        cmd_err
);

    localparam int            TW        = $clog2(POLL_DIV);
    localparam logic [TW-1:0] TIMER_MAX = TW'(POLL_DIV - 1);
    localparam logic [7:0]    TMO_LOAD  = 8'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, STORE} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          round_active;
    logic [2:0]    slot;
    logic [2:0]    cur_cmd;
    logic          cur_round;
    logic [7:0]    lo_byte;
    logic [7:0]    tmo_cnt;
    logic [15:0]   bank [6];

    logic tick;
    logic arb;
    logic host_grant;
    logic round_grant;
    logic expire;
    logic txn_end;

    assign tick        = en && (timer == TIMER_MAX);
    assign arb         = (state == IDLE) && enc_ready;
    assign host_grant  = arb && host_req;
    assign round_grant = arb && !host_req && round_active && en;
    // The ack is combinational so the host sees it in the arbitration cycle itself.
    assign host_ack    = rst_n && host_grant;
    // A byte arriving in the final wait cycle still counts; only silence expires.
    assign expire      = ((state == WAIT_LO) || (state == WAIT_HI)) && !rx_valid
                         && (tmo_cnt <= 8'd1);
    assign txn_end     = (state == STORE) || expire;
    assign busy        = (state != IDLE);

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < 6; i++) begin
            if (rd_sel == 3'(i)) rd_data = bank[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            round_active <= 1'b0;
            slot         <= '0;
            cur_cmd      <= '0;
            cur_round    <= 1'b0;
            lo_byte      <= '0;
            tmo_cnt      <= '0;
            enc_transmit <= 1'b0;
            enc_command  <= '0;
            upd_valid    <= 1'b0;
            upd_cmd      <= '0;
            timeout_err  <= 1'b0;
            overrun_err  <= 1'b0;
            cmd_err      <= 1'b0;
            for (int i = 0; i < 6; i++) bank[i] <= '0;
        end else begin
            enc_transmit <= 1'b0;
            upd_valid    <= 1'b0;

            if (!en || tick) timer <= '0;
            else             timer <= timer + TW'(1);

            // Clear first so that a same-cycle error event below overrides it.
            if (err_clr) begin
                timeout_err <= 1'b0;
                overrun_err <= 1'b0;
                cmd_err     <= 1'b0;
            end

            if (tick) begin
                if (round_active) begin
                    overrun_err <= 1'b1;
                end else begin
                    round_active <= 1'b1;
                    slot         <= '0;
                end
            end

            case (state)
                IDLE: begin
                    if (round_active && !en) begin
                        round_active <= 1'b0;
                        slot         <= '0;
                    end
                    if (host_grant) begin
                        if (host_cmd > 3'd5) begin
                            cmd_err <= 1'b1;
                        end else begin
                            state        <= ISSUE;
                            cur_cmd      <= host_cmd;
                            cur_round    <= 1'b0;
                            enc_transmit <= 1'b1;
                            enc_command  <= host_cmd;
                        end
                    end else if (round_grant) begin
                        state        <= ISSUE;
                        cur_cmd      <= slot;
                        cur_round    <= 1'b1;
                        enc_transmit <= 1'b1;
                        enc_command  <= slot;
                    end
                end
                ISSUE: begin
                    state   <= WAIT_LO;
                    tmo_cnt <= TMO_LOAD;
                end
                WAIT_LO: begin
                    if (rx_valid) begin
                        lo_byte <= rx_byte;
                        tmo_cnt <= TMO_LOAD;
                        state   <= WAIT_HI;
                    end else if (expire) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt - 8'd1;
                    end
                end
                WAIT_HI: begin
                    if (rx_valid) begin
                        for (int i = 0; i < 6; i++) begin
                            if (cur_cmd == 3'(i)) bank[i] <= {rx_byte, lo_byte};
                        end
                        upd_valid <= 1'b1;
                        upd_cmd   <= cur_cmd;
                        state     <= STORE;
                    end else if (expire) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt - 8'd1;
                    end
                end
                STORE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Round bookkeeping happens whether the slot completed or timed out.
            if (txn_end && cur_round) begin
                if ((slot == 3'd5) || !en) begin
                    round_active <= 1'b0;
                    slot         <= '0;
                end else begin
                    slot <= slot + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imu_poll_scheduler.sv
// Directed scenarios with randomized responder timing and data.
// An expected-bank array and rule-derived timeout and overrun outcomes are used to check the scheduler.
module tb_imu_poll_scheduler;

    localparam int PDIV = 16;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        host_req = 1'b0;
    logic [2:0]  host_cmd = '0;
    logic        host_ack;
    logic        enc_ready = 1'b0;
    logic        enc_transmit;
    logic [2:0]  enc_command;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic [2:0]  rd_sel = '0;
    logic [15:0] rd_data;
    logic        upd_valid;
    logic [2:0]  upd_cmd;
    logic        busy;
    logic        err_clr = 1'b0;
    logic        timeout_err;
    logic        overrun_err;
    logic        cmd_err;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_bank [6];

    imu_poll_scheduler #(.POLL_DIV(PDIV), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .host_req(host_req), .host_cmd(host_cmd), .host_ack(host_ack),
        .enc_ready(enc_ready), .enc_transmit(enc_transmit), .enc_command(enc_command),
        .rx_valid(rx_valid), .rx_byte(rx_byte),
        .rd_sel(rd_sel), .rd_data(rd_data),
        .upd_valid(upd_valid), .upd_cmd(upd_cmd), .busy(busy),
        .err_clr(err_clr), .timeout_err(timeout_err),
        .overrun_err(overrun_err), .cmd_err(cmd_err)
    );

    always #10 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_bank();
        for (int i = 0; i < 8; i++) begin
            rd_sel = 3'(i);
            #1;
            if (i < 6) check_output($sformatf("rd_data[%0d]", i), rd_data, exp_bank[i]);
            else       check_output($sformatf("rd_data[%0d]", i), rd_data, 0);
        end
    endtask

    // Called at the first wait cycle; the responder stays silent for the whole window.
    task automatic expect_timeout();
        repeat (TMO - 1) @(negedge clk);
        check_output("busy_last_wait", busy, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_output("timeout_err_set", timeout_err, 1);
        check_output("idle_after_timeout", busy, 0);
        check_output("no_upd_on_timeout", upd_valid, 0);
    endtask

    // Acts as the SPI responder for one transaction. A byte delay of d idle wait
    // cycles succeeds when d < TMO and times out otherwise.
    task automatic apply_stimulus(input logic [2:0] c, input int dlo, input int dhi,
                                  input bit junk, input bit drop_early, input bit drop_end);
        int         n;
        logic [7:0] lo;
        logic [7:0] hi;
        n  = 0;
        lo = 8'($urandom);
        hi = 8'($urandom);
        while (enc_transmit !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_output("txn_start", enc_transmit, 1);
        if (enc_transmit !== 1'b1) return;
        check_output("enc_command", enc_command, c);
        check_output("busy_issue", busy, 1);
        if (junk) begin
            rx_valid = 1'b1;
            rx_byte  = 8'hEE;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        check_output("strobe_width", enc_transmit, 0);
        if (drop_early) en = 1'b0;
        if (dlo >= TMO) begin
            expect_timeout();
            if (drop_end) en = 1'b0;
            return;
        end
        repeat (dlo) @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = lo;
        @(negedge clk);
        rx_valid = 1'b0;
        if (dhi >= TMO) begin
            expect_timeout();
            if (drop_end) en = 1'b0;
            return;
        end
        repeat (dhi) @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = hi;
        @(negedge clk);
        rx_valid = 1'b0;
        check_output("upd_valid", upd_valid, 1);
        check_output("upd_cmd", upd_cmd, c);
        check_output("enc_command_hold", enc_command, c);
        exp_bank[c] = {hi, lo};
        rd_sel = c;
        #1;
        check_output("rd_data_new", rd_data, exp_bank[c]);
        if (drop_end) en = 1'b0;
        @(negedge clk);
        check_output("upd_pulse_width", upd_valid, 0);
    endtask

    initial begin
        int         tx_seen;
        int         n;
        logic [2:0] hc;
        for (int i = 0; i < 6; i++) exp_bank[i] = '0;

        // Reset state
        #1;
        check_output("rst_host_ack", host_ack, 0);
        check_output("rst_enc_transmit", enc_transmit, 0);
        check_output("rst_enc_command", enc_command, 0);
        check_output("rst_upd_valid", upd_valid, 0);
        check_output("rst_upd_cmd", upd_cmd, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_flags", {timeout_err, overrun_err, cmd_err}, 0);
        check_bank();
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        enc_ready = 1'b1;
        @(negedge clk);
        check_output("idle_after_reset", busy, 0);

        // A full polling round; six transactions always outlast a 16-cycle tick period
        en = 1'b1;
        for (int s = 0; s < 6; s++)
            apply_stimulus(3'(s), $urandom_range(0, 3), $urandom_range(0, 3),
                           1'($urandom_range(0, 1)), 1'b0, s == 5);
        check_bank();
        check_output("round_overrun", overrun_err, 1);
        check_output("round_timeout", timeout_err, 0);
        check_output("round_cmd_err", cmd_err, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_output("overrun_cleared", overrun_err, 0);
        tx_seen = 0;
        repeat (3 * PDIV) begin
            @(negedge clk);
            if (enc_transmit === 1'b1) tx_seen++;
        end
        check_output("no_poll_when_disabled", tx_seen, 0);

        // Host request gated by enc_ready, then a minimum-latency transaction
        hc        = 3'($urandom_range(0, 5));
        enc_ready = 1'b0;
        host_req  = 1'b1;
        host_cmd  = hc;
        #1;
        check_output("no_ack_not_ready", host_ack, 0);
        @(negedge clk);
        check_output("idle_not_ready", busy, 0);
        enc_ready = 1'b1;
        #1;
        check_output("host_ack", host_ack, 1);
        @(negedge clk);
        host_req = 1'b0;
        apply_stimulus(hc, 0, 0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_output("enc_command_idle_hold", enc_command, hc);
        check_output("enc_transmit_idle", enc_transmit, 0);
        check_output("idle_after_host", busy, 0);

        // Host request in the same cycle as the poll tick wins, then the round runs
        en = 1'b1;
        repeat (PDIV - 1) @(negedge clk);
        host_req = 1'b1;
        host_cmd = 3'd3;
        #1;
        check_output("host_ack_on_tick", host_ack, 1);
        @(negedge clk);
        host_req = 1'b0;
        apply_stimulus(3'd3, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 6; s++)
            apply_stimulus(3'(s), $urandom_range(0, 3), $urandom_range(0, 3),
                           1'b0, 1'b0, s == 5);
        check_bank();

        // Timeouts on each byte and the last-cycle boundary
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_output("timeout_cleared", timeout_err, 0);
        en = 1'b1;
        apply_stimulus(3'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(3'd1, 1, TMO, 1'b0, 1'b0, 1'b0);
        apply_stimulus(3'd2, 0, TMO - 1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(3'd3, TMO, 0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(3'd4, TMO - 1, 2, 1'b1, 1'b0, 1'b0);
        apply_stimulus(3'd5, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0, 1'b1);
        check_bank();
        check_output("timeout_sticky", timeout_err, 1);

        // Illegal host commands
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_output("flags_cleared", {timeout_err, overrun_err, cmd_err}, 0);
        host_req = 1'b1;
        host_cmd = 3'd7;
        #1;
        check_output("host_ack_bad_cmd", host_ack, 1);
        @(negedge clk);
        host_req = 1'b0;
        check_output("cmd_err_set", cmd_err, 1);
        check_output("idle_bad_cmd", busy, 0);
        tx_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (enc_transmit === 1'b1) tx_seen++;
        end
        check_output("no_transmit_bad_cmd", tx_seen, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_output("cmd_err_cleared", cmd_err, 0);
        host_req = 1'b1;
        host_cmd = 3'd6;
        err_clr  = 1'b1;
        #1;
        check_output("host_ack_cmd6", host_ack, 1);
        @(negedge clk);
        host_req = 1'b0;
        err_clr  = 1'b0;
        check_output("cmd_err_set_wins", cmd_err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_output("cmd_err_cleared2", cmd_err, 0);

        // Reset while waiting for the high byte
        en = 1'b1;
        n  = 0;
        while (enc_transmit !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_output("rst_txn_start", enc_transmit, 1);
        check_output("rst_txn_slot0", enc_command, 0);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = 8'h5A;
        @(negedge clk);
        rx_valid = 1'b0;
        check_output("busy_wait_hi", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("arst_busy", busy, 0);
        check_output("arst_enc_command", enc_command, 0);
        check_output("arst_enc_transmit", enc_transmit, 0);
        check_output("arst_upd", {upd_valid, upd_cmd}, 0);
        check_output("arst_flags", {timeout_err, overrun_err, cmd_err}, 0);
        check_output("arst_host_ack", host_ack, 0);
        for (int i = 0; i < 6; i++) exp_bank[i] = '0;
        check_bank();
        repeat (2) begin
            @(negedge clk);
            check_output("arst_no_upd", upd_valid, 0);
        end
        rst_n = 1'b1;

        // Poll restarts at slot 0; en drop lets the transaction finish, then ends the round
        apply_stimulus(3'd0, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b1, 1'b0);
        tx_seen = 0;
        repeat (3 * PDIV) begin
            @(negedge clk);
            if (enc_transmit === 1'b1) tx_seen++;
        end
        check_output("round_ended_on_en_low", tx_seen, 0);
        en = 1'b1;
        for (int s = 0; s < 6; s++)
            apply_stimulus(3'(s), $urandom_range(0, 3), $urandom_range(0, 3),
                           1'($urandom_range(0, 1)), 1'b0, s == 5);
        check_bank();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imu_poll_scheduler.md
IMU_POLL_SCHEDULER -- requirements
Module: imu_poll_scheduler

Interface
REQ-001 SHALL have parameter POLL_DIV, default 1000: clk cycles per poll-round tick (>=16).
REQ-002 SHALL have parameter TIMEOUT, default 255: max clk cycles waited per received byte (8-bit counter).
REQ-003 clk  in  1  system clock, all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 en  in  1  enables periodic polling rounds.
REQ-006 host_req  in  1  one-shot request for host_cmd, held until host_ack.
REQ-007 host_cmd  in  3  requested command code 0..5.
REQ-008 host_ack  out  1  one-cycle pulse, host request accepted.
REQ-009 enc_ready  in  1  encoder idle and ready for a command.
REQ-010 enc_transmit  out  1  one-cycle command strobe to encoder.
REQ-011 enc_command  out  3  command code presented with enc_transmit.
REQ-012 rx_valid  in  1  one-cycle strobe, rx_byte valid.
REQ-013 rx_byte  in  8  received SPI byte; low byte first, then high byte.
REQ-014 rd_sel  in  3  result bank read index.
REQ-015 rd_data  out  16  bank[rd_sel], combinational; 0 for rd_sel 6..7.
REQ-016 upd_valid  out  1  one-cycle pulse, bank entry updated.
REQ-017 upd_cmd  out  3  index of entry updated, valid with upd_valid.
REQ-018 busy  out  1  high whenever state != IDLE.
REQ-019 err_clr  in  1  clears all sticky error flags.
REQ-020 timeout_err, overrun_err, cmd_err  out  1 each  sticky error flags.

Function
REQ-021 SHALL implement states IDLE, ISSUE, WAIT_LO, WAIT_HI, STORE.
REQ-022 Poll timer SHALL count 0..POLL_DIV-1 while en=1, wrap to 0, emit tick at wrap; held at 0 while en=0.
REQ-023 Tick with no round active SHALL start a round: slot pointer=0, round_active=1.
REQ-024 Tick while round_active=1 SHALL be dropped and set overrun_err.
REQ-025 IDLE SHALL arbitrate only when enc_ready=1; host_req has priority over the round slot.
REQ-026 Host grant SHALL pulse host_ack in the arbitration cycle; host_cmd 6..7 SHALL set cmd_err, start no transaction, stay IDLE.
REQ-027 Round grant SHALL use command = slot pointer (0..5, ascending order).
REQ-028 ISSUE SHALL last exactly one cycle with enc_transmit=1 and enc_command=granted code, then enter WAIT_LO.
REQ-029 enc_command SHALL hold the last issued code between transactions.
REQ-030 Entering WAIT_LO or WAIT_HI SHALL reload the timeout counter to TIMEOUT.
REQ-031 WAIT_LO: rx_valid SHALL capture low byte and go to WAIT_HI; WAIT_HI: rx_valid SHALL capture high byte and go to STORE.
REQ-032 Counter reaching 0 without rx_valid SHALL set timeout_err, leave bank unchanged, return to IDLE; rx_valid in the expiry cycle wins.
REQ-033 STORE SHALL write bank[cmd]={hi,lo}, pulse upd_valid with upd_cmd=cmd for one cycle, return to IDLE.
REQ-034 Completion or timeout of a round transaction SHALL advance the slot pointer; after slot 5, round_active SHALL clear.
REQ-035 Host transactions SHALL NOT advance the slot pointer.
REQ-036 en falling mid-round SHALL let the current transaction finish, then clear round_active and zero the pointer.
REQ-037 rx_valid in IDLE or ISSUE SHALL be ignored.
REQ-038 err_clr SHALL clear flags; simultaneous error set and err_clr SHALL leave the flag set.
REQ-039 Minimum transaction latency: grant to upd_valid = 4 cycles with rx_valid on the first WAIT_LO and WAIT_HI cycles.

Reset
REQ-040 rst_n=0 SHALL force IDLE, all outputs 0, bank 0, timer 0, pointer 0, round_active 0, error flags 0, immediately and independent of clk.
REQ-041 Reset mid-transaction SHALL abandon it without a bank write or upd_valid.

Verification
REQ-042 en=1, POLL_DIV=16, responder returns lo=cmd, hi=0xA5 -> six upd_valid pulses, upd_cmd 0..5, rd_data(i)=0xA500|i.
REQ-043 host_req cmd=3 asserted with tick in the same cycle -> host_ack, cmd 3 issued first; round then runs slots 0..5.
REQ-044 Responder silent after high byte, TIMEOUT=8 -> timeout_err=1 after 8 WAIT_HI cycles, bank unchanged, next slot issued.
REQ-045 Round in progress with slow responder (round > POLL_DIV) -> overrun_err=1, round still completes all 6 slots.
REQ-046 host_cmd=7 -> host_ack pulse, cmd_err=1, enc_transmit stays 0; err_clr -> cmd_err=0.
REQ-047 rst_n pulse low in WAIT_HI -> all outputs 0 at once, no upd_valid, first poll after release starts at slot 0.
